// File: rtl/keypad_scanner_gen.sv
// Parametrised matrix-keypad scanner: column strobing, row sync, press/release
// debounce, same-column multi-key rejection and a valid/ready key-code FIFO.
module keypad_scanner_gen #(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned SCAN_DWELL      = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH      = 4,
  localparam int unsigned CODE_W         = $clog2(ROWS * COLS),
  localparam int unsigned CNT_W          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ROWS-1:0]   Row,
  output logic [COLS-1:0]   Col,
  output logic [CODE_W-1:0] Code,
  output logic              Valid,
  input  logic              Ready,
  output logic [CNT_W-1:0]  Count,
  output logic              Overflow,
  output logic              Multi_key
);

  localparam int unsigned ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned DWELL_W = $clog2(SCAN_DWELL);
  localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_PUSH, ST_HOLD} state_t;

  state_t              r_state, w_state_nxt;
  logic [ROWS-1:0]     r_sync1, r_sync2;
  logic [DWELL_W-1:0]  r_dwell, w_dwell_nxt;
  logic [COL_W-1:0]    r_col_idx;
  logic [COLS-1:0]     r_col;
  logic [ROWS-1:0]     r_pat, w_pat_nxt;
  logic [DEB_W-1:0]    r_cnt, w_cnt_nxt;
  logic                w_col_adv, w_push, w_multi_nxt;
  logic [ROW_W-1:0]    w_row_idx;
  logic [CODE_W-1:0]   w_push_code;

  logic [CODE_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_rd, r_wr, w_rd_nxt;
  logic [CNT_W-1:0]    r_count, w_count_nxt;
  logic [CODE_W-1:0]   r_code, w_code_nxt;
  logic                r_valid, r_ovf, r_multi;
  logic                w_pop, w_full, w_wr_en, w_ovf;

  // Row index of the captured pattern (only meaningful when one-hot)
  always_comb begin
    w_row_idx = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (r_pat[i]) w_row_idx = ROW_W'(i);
    end
  end

  assign w_push_code = CODE_W'(32'(w_row_idx) * COLS + 32'(r_col_idx));

  // Next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_dwell_nxt = r_dwell;
    w_pat_nxt   = r_pat;
    w_cnt_nxt   = r_cnt;
    w_col_adv   = 1'b0;
    w_push      = 1'b0;
    w_multi_nxt = 1'b0;
    case (r_state)
      ST_SCAN: begin
        if (r_dwell == DWELL_W'(SCAN_DWELL - 1)) begin
          w_dwell_nxt = '0;
          if (r_sync2 != '0) begin
            w_pat_nxt   = r_sync2;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_DEBOUNCE;
          end else begin
            w_col_adv = 1'b1;
          end
        end else begin
          w_dwell_nxt = r_dwell + DWELL_W'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (r_sync2 != r_pat) begin
          w_cnt_nxt   = '0;
          w_col_adv   = 1'b1;
          w_dwell_nxt = '0;
          w_state_nxt = ST_SCAN;
        end else if (r_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          w_cnt_nxt = '0;
          if ($onehot(r_pat)) begin
            w_state_nxt = ST_PUSH;
          end else begin
            w_multi_nxt = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end else begin
          w_cnt_nxt = r_cnt + DEB_W'(1);
        end
      end
      ST_PUSH: begin
        w_push      = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (r_sync2 != '0) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          w_cnt_nxt   = '0;
          w_col_adv   = 1'b1;
          w_dwell_nxt = '0;
          w_state_nxt = ST_SCAN;
        end else begin
          w_cnt_nxt = r_cnt + DEB_W'(1);
        end
      end
      default: w_state_nxt = ST_SCAN;
    endcase
  end

  // FIFO bookkeeping; the head register bypasses a write landing in the head slot
  always_comb begin
    w_pop    = r_valid & Ready;
    w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    w_wr_en  = w_push & (~w_full | w_pop);
    w_ovf    = w_push & w_full & ~w_pop;
    w_rd_nxt = w_pop ? r_rd + PTR_W'(1) : r_rd;
    case ({w_wr_en, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
    if (w_count_nxt == '0)                  w_code_nxt = '0;
    else if (w_wr_en && (w_rd_nxt == r_wr)) w_code_nxt = w_push_code;
    else                                    w_code_nxt = r_mem[w_rd_nxt];
  end

  always_ff @(posedge clock) begin
    if (w_wr_en) r_mem[r_wr] <= w_push_code;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_SCAN;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_dwell   <= '0;
      r_col_idx <= '0;
      r_col     <= COLS'(1);
      r_pat     <= '0;
      r_cnt     <= '0;
      r_rd      <= '0;
      r_wr      <= '0;
      r_count   <= '0;
      r_code    <= '0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
      r_multi   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sync1 <= Row;
      r_sync2 <= r_sync1;
      r_dwell <= w_dwell_nxt;
      r_pat   <= w_pat_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_col_adv) begin
        r_col_idx <= (r_col_idx == COL_W'(COLS - 1)) ? '0 : r_col_idx + COL_W'(1);
        r_col     <= {r_col[COLS-2:0], r_col[COLS-1]};
      end
      r_rd    <= w_rd_nxt;
      if (w_wr_en) r_wr <= r_wr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_code  <= w_code_nxt;
      r_valid <= (w_count_nxt != '0);
      r_ovf   <= w_ovf;
      r_multi <= w_multi_nxt;
    end
  end

  assign Col       = r_col;
  assign Code      = r_code;
  assign Valid     = r_valid;
  assign Count     = r_count;
  assign Overflow  = r_ovf;
  assign Multi_key = r_multi;

endmodule

// File: doc/keypad_scanner_gen.md
Name: keypad_scanner_gen

Overview:
Parametrised matrix-keypad scanner, the next generation of the fixed 4x4 hex keypad block. It drives one-hot column strobes and synchronises the raw row returns internally. It debounces press and release, rejects same-column multi-key presses, and queues key codes in a FIFO drained by a valid/ready handshake. It sits between the physical keypad pins and the consumer of key codes.

Parameters:
ROWS, 4, number of keypad rows (>=2)
COLS, 4, number of keypad columns (>=2)
SCAN_DWELL, 3, cycles each column is driven during scanning (>=3, covers 2-flop sync latency)
DEBOUNCE_CYCLES, 4, consecutive stable sampled cycles needed to accept a press or a release (>=1)
FIFO_DEPTH, 4, key-code queue depth (power of 2, >=2)
Derived localparams: CODE_W=clog2(ROWS*COLS), CNT_W=clog2(FIFO_DEPTH+1)

Ports:
clock  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
Row  input  ROWS  raw asynchronous row returns, active high
Col  output  COLS  one-hot column drive, active high
Code  output  CODE_W  FIFO head key code, row*COLS+col
Valid  output  1  FIFO non-empty, Code meaningful
Ready  input  1  consumer accepts Code when Valid&Ready
Count  output  CNT_W  FIFO occupancy
Overflow  output  1  one-cycle pulse: debounced key dropped because FIFO full
Multi_key  output  1  one-cycle pulse: >1 row bit set in debounced pattern

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high, sampled on the rising edge.
- Reset state:
  - Col = 1 (column 0), Code = 0, Valid = 0, Count = 0, Overflow = 0, Multi_key = 0.
  - FSM = SCAN; sync flops, counters and FIFO pointers are cleared.
  - Reset asserted mid-operation aborts any debounce and discards the FIFO contents.
- Synchronizer: Row passes through 2 flops to S_Row. All FSM decisions use S_Row only.
- SCAN:
  - Column c is driven for SCAN_DWELL cycles.
  - S_Row is sampled on the last dwell cycle.
  - If S_Row==0, advance to c+1. Wrap COLS-1 to 0.
  - If S_Row!=0, capture pattern P and column c, then go to DEBOUNCE with Col held at c.
- DEBOUNCE:
  - Counter increments each cycle S_Row==P.
  - If S_Row!=P, clear the counter and return to SCAN at column c+1.
  - When counter reaches DEBOUNCE_CYCLES:
    - P one-hot: go to PUSH.
    - P with >1 bit: pulse Multi_key for 1 cycle, push nothing, go to HOLD.
- PUSH (1 cycle):
  - Write Code = r*COLS+c, where r is the index of the set bit in P.
  - If the FIFO is full and not popping this cycle, drop the code and pulse Overflow.
  - Go to HOLD.
- HOLD:
  - Col held at c.
  - Release counter counts consecutive cycles with S_Row==0; any nonzero S_Row clears it.
  - When it reaches DEBOUNCE_CYCLES, go to SCAN at column c+1.
  - Exactly one code per physical press; autorepeat is not supported.
- FIFO:
  - Registered. A written code is visible on Code/Valid the cycle after PUSH.
  - Pop when Valid&Ready; Code updates to the next entry on the following cycle.
  - Ready while empty is ignored. Code = 0 when empty.
  - Simultaneous push and pop: both occur and Count is unchanged. When full, the pop frees a slot, the push is accepted, and there is no Overflow.
  - Count saturates at FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- Limitations: presses in other columns during DEBOUNCE/HOLD are not seen. Multi-key detection covers the same column only.
- Minimum press-to-Valid latency: 2 (sync) + dwell remainder + DEBOUNCE_CYCLES + 1 (PUSH) + 1 cycles.

Test Plan:
- Reset then idle, Row=0: Col cycles 0001→0010→0100→1000→0001 every 3 cycles; Valid stays 0; Count=0.
- Default params, key row1/col2 held for 40 cycles, Ready=0: exactly one entry; Code=6, Valid=1, Count=1. A second press after release gives Count=2.
- Bounce: key row0/col0 toggled every 2 cycles for 20 cycles, then released: no push and Count=0. Then held stably: Code=0 queued once.
- Row bits 0 and 3 both set while column 1 driven, held: Multi_key pulses once, Count unchanged, release returns to scanning column 2.
- FIFO_DEPTH=4, Ready=0, five distinct presses (codes 1,2,3,4,5): Count=4, Overflow pulses on the 5th. Ready=1 then drains 1,2,3,4 in order, one per cycle, Valid drops after the 4th.
- Push coinciding with pop while full: Count stays 4, no Overflow. reset asserted during HOLD: all outputs return to reset values the next cycle.
